// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALUCtrl op codes shared with the ALU control decoder, and the exec FSM state encoding
package alu_ctrl_pkg;
    localparam int CTRL_W = 4;
    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_DIV  = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_NOT  = 4'b1001;
    localparam logic [CTRL_W-1:0] ALU_MULT = 4'b1111;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned shift-add multiplier / restoring divider, one bit per cycle;
//   go/is_div/a/b launch an op, step_done flags the final step, hi/lo carry that step's result
//   (mult: product high/low, div: remainder/quotient) so the caller can register it on the same edge
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             step_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    logic run, div_r;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] acc, sh, op;
    logic [WIDTH:0] sum, trial;
    // acc is the product high word / partial remainder; sh is the multiplier / dividend-quotient shifter
    always_comb begin
        sum = {1'b0, acc} + (sh[0] ? {1'b0, op} : '0);
        trial = {acc, sh[WIDTH-1]} - {1'b0, op};
        hi = div_r ? (trial[WIDTH] ? {acc[WIDTH-2:0], sh[WIDTH-1]} : trial[WIDTH-1:0]) : sum[WIDTH:1];
        lo = div_r ? {sh[WIDTH-2:0], ~trial[WIDTH]} : {sum[0], sh[WIDTH-1:1]};
        step_done = run && cnt == '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run <= 1'b0;
            div_r <= 1'b0;
            cnt <= '0;
            acc <= '0;
            sh <= '0;
            op <= '0;
        end else if (go) begin
            run <= 1'b1;
            div_r <= is_div;
            cnt <= CW'(WIDTH - 1);
            acc <= '0;
            sh <= is_div ? a : b;
            op <= is_div ? b : a;
        end else if (run) begin
            acc <= hi;
            sh <= lo;
            cnt <= cnt - 1'b1;
            run <= cnt != '0;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with single-cycle ops and iterative mult/div behind start/busy/done;
//   in: clk, reset, start, alu_ctrl, a, b, shamt; out: result, zero, hi, lo, busy, done
module alu_exec_unit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = alu_ctrl_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [4:0]        shamt,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo,
    output logic              busy,
    output logic              done
);
    state_t state, nxt;
    logic [WIDTH-1:0] alu_out, md_hi, md_lo;
    logic accept, is_mul, is_div, div_zero, go, step_done;
    assign accept = state == S_IDLE && start;
    assign is_mul = alu_ctrl == ALU_MULT;
    assign is_div = alu_ctrl == ALU_DIV;
    assign div_zero = is_div && b == '0;
    assign go = accept && (is_mul || (is_div && !div_zero));
    alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk(clk), .reset(reset), .go(go), .is_div(is_div), .a(a), .b(b),
        .step_done(step_done), .hi(md_hi), .lo(md_lo)
    );
    always_comb begin
        alu_out = alu_ctrl == ALU_ADD ? a + b :
                  alu_ctrl == ALU_SUB ? a - b :
                  alu_ctrl == ALU_AND ? a & b :
                  alu_ctrl == ALU_OR  ? a | b :
                  alu_ctrl == ALU_SLT ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} :
                  alu_ctrl == ALU_SLL ? b << shamt :
                  alu_ctrl == ALU_SRL ? b >> shamt :
                  alu_ctrl == ALU_NOT ? ~a : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= nxt;
    end
    // divide-by-zero and single-cycle ops skip the iterative states
    always_comb begin
        nxt = state == S_IDLE ? (!start ? S_IDLE : is_mul ? S_MUL : go ? S_DIV : S_DONE) :
              state == S_DONE ? S_IDLE :
              step_done ? S_DONE : state;
    end
    always_comb begin
        busy = state != S_IDLE;
        done = state == S_DONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
            zero <= 1'b1;
            hi <= '0;
            lo <= '0;
        end else if (accept && !go) begin
            result <= div_zero ? '1 : alu_out;
            zero <= div_zero ? 1'b0 : alu_out == '0;
            if (div_zero) begin
                hi <= a;
                lo <= '1;
            end
        end else if ((state == S_MUL || state == S_DIV) && step_done) begin
            result <= md_lo;
            zero <= md_lo == '0;
            hi <= md_hi;
            lo <= md_lo;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random checks of alu_exec_unit against an arithmetic reference model
module tb_alu_exec_unit;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [3:0] alu_ctrl = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0] shamt = '0;
    logic [31:0] result, hi, lo;
    logic zero, busy, done;
    logic [31:0] mhi = '0, mlo = '0, mres;
    int n_assert = 0, n_fail = 0;
    int lat;
    alu_exec_unit dut (
        .clk(clk), .reset(reset), .start(start), .alu_ctrl(alu_ctrl), .a(a), .b(b), .shamt(shamt),
        .result(result), .zero(zero), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
        longint unsigned p;
        case (c)
            4'b0010: mres = x + y;
            4'b0110: mres = x - y;
            4'b0000: mres = x & y;
            4'b0001: mres = x | y;
            4'b0111: mres = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'b0101: mres = y << s;
            4'b1000: mres = y >> s;
            4'b1001: mres = ~x;
            4'b1111: begin
                p = longint'(x) * longint'(y);
                mhi = p[63:32];
                mlo = p[31:0];
                mres = mlo;
            end
            4'b0011: begin
                mlo = (y == 0) ? 32'hFFFFFFFF : x / y;
                mhi = (y == 0) ? x : x % y;
                mres = mlo;
            end
            default: mres = 0;
        endcase
    endtask
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
        int exp_lat;
        exp_lat = (c == 4'b1111 || (c == 4'b0011 && y != 0)) ? 33 : 1;
        model(c, x, y, s);
        @(negedge clk);
        start = 1'b1; alu_ctrl = c; a = x; b = y; shamt = s;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, 64'(result), 64'(mres));
        chk({tag, " zero"}, 64'(zero), 64'(mres == 0));
        chk({tag, " hi"}, 64'(hi), 64'(mhi));
        chk({tag, " lo"}, 64'(lo), 64'(mlo));
        chk({tag, " busy at done"}, 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk({tag, " busy after"}, 64'(busy), 64'd0);
        chk({tag, " done after"}, 64'(done), 64'd0);
    endtask
    localparam logic [3:0] CODES [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
                                          4'b0111, 4'b1000, 4'b1001, 4'b1111, 4'b0100, 4'b1010};
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", 64'(result), 64'd0);
        chk("reset zero", 64'(zero), 64'd1);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("add", 4'b0010, 32'd5, 32'd7, 5'd0);
        run_op("sub", 4'b0110, 32'd7, 32'd7, 5'd0);
        run_op("slt", 4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0);
        run_op("srl", 4'b1000, 32'd0, 32'h80000000, 5'd4);
        run_op("mult", 4'b1111, 32'hFFFFFFFF, 32'd2, 5'd0);
        run_op("div", 4'b0011, 32'd100, 32'd7, 5'd0);
        run_op("div0", 4'b0011, 32'd100, 32'd0, 5'd0);
        // adds pulsed throughout a mult must be ignored
        @(negedge clk);
        start = 1'b1; alu_ctrl = 4'b1111; a = 32'd123456; b = 32'd654321;
        model(4'b1111, 32'd123456, 32'd654321, 5'd0);
        @(posedge clk);
        #1;
        alu_ctrl = 4'b0010; a = 32'd1; b = 32'd2;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("stall latency", 64'(lat), 64'd33);
        chk("stall hi", 64'(hi), 64'(mhi));
        chk("stall lo", 64'(lo), 64'(mlo));
        @(posedge clk);
        #1;
        chk("stall idle done", 64'(done), 64'd0);
        chk("stall idle result", 64'(result), 64'(mlo));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("stall next add done", 64'(done), 64'd1);
        chk("stall next add result", 64'(result), 64'd3);
        @(posedge clk);
        #1;
        // reset 10 cycles into a mult
        @(negedge clk);
        start = 1'b1; alu_ctrl = 4'b1111; a = 32'd99; b = 32'd77;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort hi", 64'(hi), 64'd0);
        chk("abort lo", 64'(lo), 64'd0);
        chk("abort result", 64'(result), 64'd0);
        mhi = 0;
        mlo = 0;
        @(negedge clk);
        reset = 1'b0;
        run_op("mult 3x4", 4'b1111, 32'd3, 32'd4, 5'd0);
        for (int i = 0; i < 30; i++) begin
            logic [3:0] c;
            logic [31:0] y;
            c = CODES[$urandom_range(0, 11)];
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op("rand", c, $urandom, y, 5'($urandom_range(0, 31)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
